// File: rtl/idma_eh_responder.sv
// iDMA error-handling responder: watches the 1D response stream,
// records bus errors and hands a CONTINUE/ABORT decision back to the backend.
module idma_eh_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic                 rsp_last_i,
  input  logic                 rsp_error_i,
  input  logic [1:0]           rsp_cause_i,
  input  logic [1:0]           rsp_err_type_i,
  input  logic [AddrWidth-1:0] rsp_burst_addr_i,
  output logic                 eh_o,
  output logic                 eh_valid_o,
  input  logic                 eh_ready_i,
  input  logic [1:0]           policy_i,
  input  logic                 sw_decision_i,
  input  logic                 sw_valid_i,
  output logic                 sw_ready_o,
  input  logic                 err_clear_i,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [1:0]           err_cause_o,
  output logic [1:0]           err_type_o,
  output logic                 err_pending_o,
  output logic [CntWidth-1:0]  err_count_o,
  output logic [CntWidth-1:0]  done_count_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    ISSUE
  } state_e;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e state_q, state_d;
  logic   dec_q, dec_d;
  logic   rsp_hs, err_hs, done_hs;

  assign rsp_hs  = rsp_valid_i & rsp_ready_o;
  assign err_hs  = rsp_hs & rsp_error_i;
  assign done_hs = rsp_hs & ~rsp_error_i & rsp_last_i;

  // eh_o only carries meaning while a decision is offered
  assign eh_o = eh_valid_o & dec_q;

  // next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    rsp_ready_o = 1'b0;
    sw_ready_o  = 1'b0;
    eh_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rsp_ready_o = 1'b1;
        if (rsp_valid_i && rsp_error_i) begin
          // policy is frozen here; later policy_i changes are ignored
          dec_d   = policy_i[0];
          state_d = policy_i[1] ? DECIDE : ISSUE;
        end
      end
      DECIDE: begin
        sw_ready_o = 1'b1;
        if (sw_valid_i) begin
          dec_d   = sw_decision_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eh_valid_o = 1'b1;
        if (eh_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and decision register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  // error record; clear leaves the fields, a capture overwrites them
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_addr_o  <= '0;
      err_cause_o <= '0;
      err_type_o  <= '0;
      irq_o       <= 1'b0;
    end else begin
      irq_o <= err_hs;
      if (err_hs) begin
        err_addr_o  <= rsp_burst_addr_i;
        err_cause_o <= rsp_cause_i;
        err_type_o  <= rsp_err_type_i;
      end
    end
  end

  // pending flag and counters; a capture beats a coincident clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_pending_o <= 1'b0;
      err_count_o   <= '0;
      done_count_o  <= '0;
    end else begin
      if (err_hs) begin
        err_pending_o <= 1'b1;
      end else if (err_clear_i) begin
        err_pending_o <= 1'b0;
      end

      if (err_hs) begin
        if (err_clear_i) begin
          err_count_o <= CntOne;
        end else if (err_count_o != '1) begin
          err_count_o <= err_count_o + CntOne;
        end
      end else if (err_clear_i) begin
        err_count_o <= '0;
      end

      if (err_clear_i) begin
        done_count_o <= '0;
      end else if (done_hs) begin
        done_count_o <= done_count_o + CntOne;
      end
    end
  end

endmodule
